// File: rtl/modulo_controle_rolhas.sv
// Sequencing controller for the cork-stock register.
// Owns every write to the register: bulk loads via its asynchronous load
// path, saturating batch refills and one-cork decrements per capped bottle.
// Also runs the dispense/seat handshake with the capping station.
module modulo_controle_rolhas #(
    parameter int MAX_CORKS  = 100,
    parameter int BATCH      = 10,
    parameter int LOW_THRESH = 5,
    parameter int TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       load_req,
    input  logic [6:0] load_value,
    input  logic       add_req,
    input  logic       cap_req,
    input  logic       cork_ok,
    input  logic [6:0] reg_q,
    output logic [6:0] reg_d,
    output logic       reg_en,
    output logic       reg_load,
    output logic [6:0] reg_e_load,
    output logic       dispense,
    output logic       cap_done,
    output logic       cap_fail,
    output logic       busy,
    output logic       empty,
    output logic       low
);

    localparam logic [6:0] MAX_Q     = 7'(MAX_CORKS);
    localparam logic [7:0] MAX_W     = 8'(MAX_CORKS);
    localparam logic [7:0] BATCH_W   = 8'(BATCH);
    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);
    localparam logic [6:0] LOW_Q     = 7'(LOW_THRESH);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_ADD      = 3'd2;
    localparam logic [2:0] ST_DISPENSE = 3'd3;
    localparam logic [2:0] ST_WAIT     = 3'd4;
    localparam logic [2:0] ST_DEC      = 3'd5;
    localparam logic [2:0] ST_FAIL     = 3'd6;
    localparam logic [2:0] ST_RELEASE  = 3'd7;

    logic [2:0] state;
    logic [2:0] state_next;
    logic       pending;
    logic [7:0] timer;
    logic [6:0] load_hold;

    // A refill request arriving in IDLE is acted on at once rather than
    // waiting a cycle for the pending flag to be registered.
    logic       add_seen;
    logic [7:0] timer_inc;
    logic [7:0] add_sum;
    logic [6:0] add_value;
    logic [6:0] load_sat;

    assign add_seen  = pending | add_req;
    assign timer_inc = timer + 8'd1;
    assign add_sum   = {1'b0, reg_q} + BATCH_W;
    assign add_value = (add_sum > MAX_W) ? MAX_Q : add_sum[6:0];
    assign load_sat  = (load_value > MAX_Q) ? MAX_Q : load_value;

    // Stock flags follow the register directly, independent of reset.
    assign empty = (reg_q == 7'd0);
    assign low   = (reg_q <= LOW_Q);

    // Next-state selection; IDLE priority is load, then refill, then capping.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (load_req)
                    state_next = ST_LOAD;
                else if (add_seen)
                    state_next = ST_ADD;
                else if (cap_req && reg_q != 7'd0)
                    state_next = ST_DISPENSE;
            end
            ST_LOAD:     state_next = ST_IDLE;
            ST_ADD:      state_next = ST_IDLE;
            ST_DISPENSE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (cork_ok)
                    state_next = ST_DEC;
                else if (timer_inc == TIMEOUT_W)
                    state_next = ST_FAIL;
            end
            ST_DEC:      state_next = ST_RELEASE;
            ST_FAIL:     state_next = ST_RELEASE;
            ST_RELEASE: begin
                if (!cap_req)
                    state_next = ST_IDLE;
            end
            default:     state_next = ST_IDLE;
        endcase
    end

    // State, refill flag, seat timer and captured load value.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= ST_IDLE;
            pending   <= 1'b0;
            timer     <= 8'd0;
            load_hold <= 7'd0;
        end else begin
            state <= state_next;
            // add_req in the ADD cycle itself re-arms the flag so it is not lost.
            if (state == ST_ADD)
                pending <= add_req;
            else
                pending <= pending | add_req;
            if (state == ST_DISPENSE)
                timer <= 8'd0;
            else if (state == ST_WAIT && !cork_ok)
                timer <= timer_inc;
            if (state == ST_IDLE && load_req)
                load_hold <= load_sat;
        end
    end

    // Moore output decode; the register holds its value unless told otherwise.
    always_comb begin
        reg_d      = reg_q;
        reg_en     = 1'b0;
        reg_load   = 1'b0;
        reg_e_load = 7'd0;
        dispense   = 1'b0;
        cap_done   = 1'b0;
        cap_fail   = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_LOAD: begin
                reg_load   = 1'b1;
                reg_e_load = load_hold;
            end
            ST_ADD: begin
                reg_d  = add_value;
                reg_en = 1'b1;
            end
            ST_DISPENSE: dispense = 1'b1;
            ST_DEC: begin
                reg_d    = reg_q - 7'd1;
                reg_en   = 1'b1;
                cap_done = 1'b1;
            end
            ST_FAIL:     cap_fail = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_modulo_controle_rolhas.sv
// Testbench for the cork-stock controller. Includes a behavioural model of
// the stock register (async load path, synchronous enable) and a
// transaction-level stock model computed from the refill/cap rules.
module tb_modulo_controle_rolhas;

    localparam int MAXC = 100;
    localparam int BAT  = 10;
    localparam int LOWT = 5;
    localparam int TMO  = 15;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       load_req = 1'b0;
    logic [6:0] load_value = 7'd0;
    logic       add_req = 1'b0;
    logic       cap_req = 1'b0;
    logic       cork_ok = 1'b0;
    logic [6:0] reg_q;
    logic [6:0] reg_d;
    logic       reg_en;
    logic       reg_load;
    logic [6:0] reg_e_load;
    logic       dispense;
    logic       cap_done;
    logic       cap_fail;
    logic       busy;
    logic       empty;
    logic       low;

    modulo_controle_rolhas #(
        .MAX_CORKS(MAXC), .BATCH(BAT), .LOW_THRESH(LOWT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .clr(clr), .load_req(load_req), .load_value(load_value),
        .add_req(add_req), .cap_req(cap_req), .cork_ok(cork_ok), .reg_q(reg_q),
        .reg_d(reg_d), .reg_en(reg_en), .reg_load(reg_load), .reg_e_load(reg_e_load),
        .dispense(dispense), .cap_done(cap_done), .cap_fail(cap_fail),
        .busy(busy), .empty(empty), .low(low)
    );

    always #5 clk = ~clk;

    // Stock register model: load is transparent while asserted.
    logic [6:0] stock_reg = 7'd0;
    assign reg_q = reg_load ? reg_e_load : stock_reg;
    always @(posedge clk) begin
        if (reg_load)
            stock_reg <= reg_e_load;
        else if (reg_en)
            stock_reg <= reg_d;
    end

    // Pulse counters over whole run.
    int n_disp = 0, n_done = 0, n_fail = 0, n_add = 0;
    always @(posedge clk) begin
        if (dispense) n_disp++;
        if (cap_done) n_done++;
        if (cap_fail) n_fail++;
        if (reg_en && !cap_done) n_add++;
    end

    int n_checks = 0;
    int n_err    = 0;
    int model    = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int sat_add(input int s);
        return (s + BAT > MAXC) ? MAXC : s + BAT;
    endfunction

    task automatic chk_stock(input string tag);
        chk({tag, ".q"}, int'(reg_q), model);
        chk({tag, ".empty"}, int'(empty), int'(model == 0));
        chk({tag, ".low"}, int'(low), int'(model <= LOWT));
    endtask

    task automatic do_load(input int v);
        int exp;
        exp = (v > MAXC) ? MAXC : v;
        load_req = 1'b1;
        load_value = 7'(v);
        step();
        chk("load.reg_load", int'(reg_load), 1);
        chk("load.e_load", int'(reg_e_load), exp);
        load_req = 1'b0;
        step();
        model = exp;
        chk("load.busy", int'(busy), 0);
        chk("load.reg_load_off", int'(reg_load), 0);
        chk_stock("load");
        $display("load %0d -> stock %0d", v, model);
    endtask

    task automatic do_add();
        int a0;
        a0 = n_add;
        add_req = 1'b1;
        step();
        chk("add.reg_en", int'(reg_en), 1);
        add_req = 1'b0;
        step();
        model = sat_add(model);
        chk("add.count", n_add - a0, 1);
        chk_stock("add");
        $display("add -> stock %0d", model);
    endtask

    // Handshake from the DISPENSE cycle onward. j in 1..TMO seats on WAIT cycle j.
    task automatic cap_body(input int j, input bit with_adds);
        int w, d0, f0, a0;
        bit ok;
        d0 = n_done; f0 = n_fail; a0 = n_add;
        ok = (j >= 1 && j <= TMO);
        step();
        w = 1;
        while (w < 300) begin
            cork_ok = (w == j);
            add_req = with_adds && (w <= 2);
            step();
            cork_ok = 1'b0;
            add_req = 1'b0;
            if (cap_done || cap_fail) break;
            w++;
        end
        chk("cap.wait_cycles", w, ok ? j : TMO);
        chk("cap.done", int'(cap_done), int'(ok));
        chk("cap.fail", int'(cap_fail), int'(!ok));
        step();
        if (ok) model = model - 1;
        chk("cap.release_busy", int'(busy), 1);
        chk_stock("cap");
        step();
        chk("cap.hold_release", int'(busy), 1);
        cap_req = 1'b0;
        step();
        chk("cap.idle", int'(busy), 0);
        chk("cap.done_count", n_done - d0, int'(ok));
        chk("cap.fail_count", n_fail - f0, int'(!ok));
        if (with_adds) begin
            step();
            step();
            model = sat_add(model);
            chk_stock("cap.late_add");
        end
        chk("cap.add_count", n_add - a0, int'(with_adds));
        $display("cap j=%0d adds=%0d -> %s stock %0d", j, with_adds, ok ? "done" : "fail", model);
    endtask

    task automatic do_cap(input int j, input bit with_adds);
        int d0;
        d0 = n_disp;
        cap_req = 1'b1;
        if (model == 0) begin
            step(); step(); step();
            chk("capempty.busy", int'(busy), 0);
            chk("capempty.disp", n_disp - d0, 0);
            chk("capempty.empty", int'(empty), 1);
            cap_req = 1'b0;
            step();
            $display("cap on empty stock ignored");
        end else begin
            step();
            chk("cap.dispense", int'(dispense), 1);
            cap_body(j, with_adds);
            chk("cap.disp_count", n_disp - d0, 1);
        end
    endtask

    initial begin
        int op, d0, f0;
        // Reset state
        step(); step(); step();
        chk("rst.busy", int'(busy), 0);
        chk("rst.dispense", int'(dispense), 0);
        chk("rst.reg_en", int'(reg_en), 0);
        chk("rst.reg_load", int'(reg_load), 0);
        chk_stock("rst");
        clr = 1'b1;
        step();

        // Bulk load saturation, normal cap, timeout
        do_load(120);
        do_load(6);
        do_cap(3, 1'b0);
        do_load(6);
        do_cap(0, 1'b0);

        // Refill saturation, empty stock then refill lets cap proceed
        do_load(95);
        do_add();
        do_load(0);
        cap_req = 1'b1;
        d0 = n_disp;
        step(); step();
        chk("empty.disp", n_disp - d0, 0);
        chk("empty.flag", int'(empty), 1);
        add_req = 1'b1;
        step();
        add_req = 1'b0;
        chk("empty.add_en", int'(reg_en), 1);
        step();
        model = sat_add(model);
        chk_stock("empty.refill");
        step();
        chk("empty.dispense", int'(dispense), 1);
        cap_body(1, 1'b0);
        $display("empty then refill then cap -> stock %0d", model);

        // Load, add and cap together: LOAD, ADD, DISPENSE in that order
        load_req = 1'b1; load_value = 7'd30; add_req = 1'b1; cap_req = 1'b1;
        step();
        chk("sim.load", int'(reg_load), 1);
        chk("sim.load_q", int'(reg_q), 30);
        load_req = 1'b0; add_req = 1'b0;
        model = 30;
        step();
        chk("sim.idle1", int'(busy), 0);
        step();
        chk("sim.add", int'(reg_en), 1);
        chk("sim.add_d", int'(reg_d), 40);
        step();
        model = 40;
        chk("sim.idle2", int'(busy), 0);
        step();
        chk("sim.dispense", int'(dispense), 1);
        cap_body(2, 1'b1);
        $display("simultaneous load/add/cap -> stock %0d", model);

        // Reset mid-cap
        do_load(40);
        d0 = n_done; f0 = n_fail;
        cap_req = 1'b1;
        step(); step(); step();
        #2 clr = 1'b0;
        #1;
        chk("rstmid.busy", int'(busy), 0);
        chk("rstmid.dispense", int'(dispense), 0);
        chk("rstmid.reg_en", int'(reg_en), 0);
        cap_req = 1'b0;
        step(); step();
        chk_stock("rstmid");
        clr = 1'b1;
        step();
        chk("rstmid.done", n_done - d0, 0);
        chk("rstmid.fail", n_fail - f0, 0);
        chk("rstmid.idle", int'(busy), 0);
        $display("reset mid-cap -> stock %0d", model);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: do_load(int'($urandom_range(0, 127)));
                1: do_add();
                default: do_cap(int'($urandom_range(0, TMO + 2)), $urandom_range(0, 3) == 0);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
